// File: rtl/mvslice_uinst_sched_pkg.sv
// Shared types for the MV-slice micro-instruction scheduler: accumulator ops,
// FSM states and micro-instruction field layout at the default widths.
package mvslice_uinst_sched_pkg;

  localparam int TAGW_DEF        = 8;
  localparam int MV_RF_DEPTH_DEF = 512;
  localparam int ACCUM_DEPTH_DEF = 512;
  localparam int LENW_DEF        = 8;
  localparam int ROWSW_DEF       = 8;

  // Micro-instruction layout, MSB->LSB: {tag, rf_addr, load, accum_addr, accum_op}
  localparam int UI_OP_W      = 2;
  localparam int UI_OP_LSB    = 0;
  localparam int UI_ACCUM_W   = $clog2(ACCUM_DEPTH_DEF);
  localparam int UI_ACCUM_LSB = UI_OP_LSB + UI_OP_W;
  localparam int UI_LOAD_LSB  = UI_ACCUM_LSB + UI_ACCUM_W;
  localparam int UI_RF_W      = $clog2(MV_RF_DEPTH_DEF);
  localparam int UI_RF_LSB    = UI_LOAD_LSB + 1;
  localparam int UI_TAG_W     = TAGW_DEF;
  localparam int UI_TAG_LSB   = UI_RF_LSB + UI_RF_W;
  localparam int UI_W         = UI_TAG_LSB + UI_TAG_W;

  typedef enum logic [1:0] {
    ACC_OP_SET    = 2'd0,
    ACC_OP_ACC    = 2'd1,
    ACC_OP_SET_WB = 2'd2,
    ACC_OP_ACC_WB = 2'd3
  } accum_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/mvslice_uinst_sched_if.sv
// Macro-instruction input channel and micro-instruction output channel of the
// scheduler; slave is the scheduler's view, master the decoder/slice side.
interface mvslice_uinst_sched_if #(
  parameter int TAGW        = 8,
  parameter int MV_RF_ADDRW = 9,
  parameter int ACCUM_ADDRW = 9,
  parameter int LENW        = 8,
  parameter int ROWSW       = 8,
  parameter int MVSLICE_UIW = TAGW + MV_RF_ADDRW + 1 + ACCUM_ADDRW + 2
);
  logic                   i_minst_valid;
  logic                   o_minst_ready;
  logic [MV_RF_ADDRW-1:0] i_minst_rf_base;
  logic [LENW-1:0]        i_minst_len_m1;
  logic [ROWSW-1:0]       i_minst_rows_m1;
  logic [ACCUM_ADDRW-1:0] i_minst_accum_base;
  logic                   i_minst_accum_en;
  logic                   i_minst_load;
  logic [TAGW-1:0]        i_minst_tag;
  logic [MVSLICE_UIW-1:0] o_uinst_data;
  logic                   o_uinst_valid;
  logic                   i_uinst_ready;

  modport slave (
    input  i_minst_valid, i_minst_rf_base, i_minst_len_m1, i_minst_rows_m1,
           i_minst_accum_base, i_minst_accum_en, i_minst_load, i_minst_tag,
           i_uinst_ready,
    output o_minst_ready, o_uinst_data, o_uinst_valid
  );

  modport master (
    output i_minst_valid, i_minst_rf_base, i_minst_len_m1, i_minst_rows_m1,
           i_minst_accum_base, i_minst_accum_en, i_minst_load, i_minst_tag,
           i_uinst_ready,
    input  o_minst_ready, o_uinst_data, o_uinst_valid
  );
endinterface

// File: rtl/mvslice_uinst_sched_loop_ctr.sv
// Two-level nested counter (chunk inner, row outer) with first/last flags;
// limits are captured on load and the count advances on en_i.
module mvslice_uinst_sched_loop_ctr #(
  parameter int LENW  = 8,
  parameter int ROWSW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LENW-1:0]  len_m1_i,
  input  logic [ROWSW-1:0] rows_m1_i,
  input  logic             en_i,
  output logic             chunk_first_o,
  output logic             chunk_last_o,
  output logic             row_last_o
);

  logic [LENW-1:0]  chunk_q;
  logic [LENW-1:0]  len_m1_q;
  logic [ROWSW-1:0] row_q;
  logic [ROWSW-1:0] rows_m1_q;

  assign chunk_first_o = (chunk_q == '0);
  assign chunk_last_o  = (chunk_q == len_m1_q);
  assign row_last_o    = (row_q == rows_m1_q);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_q   <= '0;
      len_m1_q  <= '0;
      row_q     <= '0;
      rows_m1_q <= '0;
    end else if (load_i) begin
      chunk_q   <= '0;
      len_m1_q  <= len_m1_i;
      row_q     <= '0;
      rows_m1_q <= rows_m1_i;
    end else if (en_i) begin
      if (chunk_last_o) begin
        chunk_q <= '0;
        row_q   <= row_q + 1'b1;
      end else begin
        chunk_q <= chunk_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mvslice_uinst_sched.sv
// Expands one matrix-vector macro-instruction into per-chunk micro-instructions
// for an MV slice. Optional perf counters: define MVSLICE_SCHED_PERF_EN.
module mvslice_uinst_sched
  import mvslice_uinst_sched_pkg::*;
#(
  parameter int TAGW        = TAGW_DEF,
  parameter int MV_RF_DEPTH = MV_RF_DEPTH_DEF,
  parameter int MV_RF_ADDRW = $clog2(MV_RF_DEPTH),
  parameter int ACCUM_DEPTH = ACCUM_DEPTH_DEF,
  parameter int ACCUM_ADDRW = $clog2(ACCUM_DEPTH),
  parameter int LENW        = LENW_DEF,
  parameter int ROWSW       = ROWSW_DEF,
  parameter int MVSLICE_UIW = TAGW + MV_RF_ADDRW + 1 + ACCUM_ADDRW + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mvslice_uinst_sched_if.slave  bus,
`ifdef MVSLICE_SCHED_PERF_EN
  output logic [31:0]           o_perf_issued,
  output logic [31:0]           o_perf_stall,
`endif
  output logic                  o_busy
);

  sched_state_e           state_q;
  logic [TAGW-1:0]        tag_q;
  logic                   load_q;
  logic                   accum_en_q;
  logic [MV_RF_ADDRW-1:0] rf_addr_q;
  logic [ACCUM_ADDRW-1:0] accum_addr_q;

  logic      chunk_first;
  logic      chunk_last;
  logic      row_last;
  logic      issuing;
  logic      xfer;
  logic      last_xfer;
  logic      accept;
  accum_op_e op;

  assign issuing   = (state_q == ST_ISSUE);
  assign xfer      = issuing && bus.i_uinst_ready;
  assign last_xfer = xfer && chunk_last && row_last;

  // Ready rises combinationally on the final transfer so a waiting macro can
  // be taken in the same cycle and issue without a bubble.
  assign bus.o_minst_ready = (state_q == ST_IDLE) || last_xfer;
  assign accept            = bus.i_minst_valid && bus.o_minst_ready;

  mvslice_uinst_sched_loop_ctr #(
    .LENW  (LENW),
    .ROWSW (ROWSW)
  ) u_loop_ctr (
    .clk           (clk),
    .rst           (rst),
    .load_i        (accept),
    .len_m1_i      (bus.i_minst_len_m1),
    .rows_m1_i     (bus.i_minst_rows_m1),
    .en_i          (xfer),
    .chunk_first_o (chunk_first),
    .chunk_last_o  (chunk_last),
    .row_last_o    (row_last)
  );

  // First and last chunks carry the row's op (overwrite or add); the last adds write-back.
  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise a latch is inferred.
  always_comb begin
    op = ACC_OP_ACC;
    if (chunk_last) begin
      op = accum_en_q ? ACC_OP_ACC_WB : ACC_OP_SET_WB;
    end else if (chunk_first) begin
      op = accum_en_q ? ACC_OP_ACC : ACC_OP_SET;
    end
  end

  assign bus.o_uinst_valid = issuing;
  assign o_busy            = issuing;

  // Data is forced to zero while idle so reset and idle present an all-zero bus.
  assign bus.o_uinst_data = issuing
    ? MVSLICE_UIW'({tag_q, rf_addr_q, load_q, accum_addr_q, op})
    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      load_q       <= 1'b0;
      accum_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      accum_addr_q <= '0;
    end else if (accept) begin
      state_q      <= ST_ISSUE;
      tag_q        <= bus.i_minst_tag;
      load_q       <= bus.i_minst_load;
      accum_en_q   <= bus.i_minst_accum_en;
      rf_addr_q    <= bus.i_minst_rf_base;
      accum_addr_q <= bus.i_minst_accum_base;
    end else if (xfer) begin
      // Chunks of consecutive rows are contiguous, so the RF address is a plain incrementer.
      rf_addr_q <= rf_addr_q + 1'b1;
      if (chunk_last) begin
        accum_addr_q <= accum_addr_q + 1'b1;
      end
      if (row_last && chunk_last) begin
        state_q <= ST_IDLE;
      end
    end
  end

`ifdef MVSLICE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_issued <= '0;
      o_perf_stall  <= '0;
    end else begin
      if (xfer && (o_perf_issued != '1)) begin
        o_perf_issued <= o_perf_issued + 1'b1;
      end
      if (issuing && !bus.i_uinst_ready && (o_perf_stall != '1)) begin
        o_perf_stall <= o_perf_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mvslice_uinst_sched.sv
// Directed self-checking bench for mvslice_uinst_sched: expansion order,
// accumulator ops, address wrap, backpressure, back-to-back macros and reset.
module tb_mvslice_uinst_sched;
  import mvslice_uinst_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mvslice_uinst_sched_if bus ();

`ifdef MVSLICE_SCHED_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  mvslice_uinst_sched dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
`ifdef MVSLICE_SCHED_PERF_EN
    .o_perf_issued (perf_issued),
    .o_perf_stall  (perf_stall),
`endif
    .o_busy        (busy)
  );

  function automatic logic [UI_W-1:0] pack_ui(int tag, int rf, int ld, int acc, int op);
    logic [UI_W-1:0] v;
    v = '0;
    v[UI_TAG_LSB +: UI_TAG_W]     = UI_TAG_W'(tag);
    v[UI_RF_LSB +: UI_RF_W]       = UI_RF_W'(rf);
    v[UI_LOAD_LSB]                = ld[0];
    v[UI_ACCUM_LSB +: UI_ACCUM_W] = UI_ACCUM_W'(acc);
    v[UI_OP_LSB +: UI_OP_W]       = UI_OP_W'(op);
    return v;
  endfunction

  task automatic set_fields(int rf, int len, int rows, int ab, int ae, int ld, int tag);
    bus.i_minst_rf_base    = 9'(rf);
    bus.i_minst_len_m1     = 8'(len);
    bus.i_minst_rows_m1    = 8'(rows);
    bus.i_minst_accum_base = 9'(ab);
    bus.i_minst_accum_en   = ae[0];
    bus.i_minst_load       = ld[0];
    bus.i_minst_tag        = 8'(tag);
  endtask

  // Presents a macro for one cycle from idle, then scrambles the fields so any
  // late sampling by the DUT would show up in the data checks.
  task automatic send_macro(int rf, int len, int rows, int ab, int ae, int ld, int tag);
    @(negedge clk);
    set_fields(rf, len, rows, ab, ae, ld, tag);
    bus.i_minst_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_minst_valid = 1'b0;
    set_fields(341, 7, 5, 77, ~ae, ~ld, 8'hEE);
  endtask

  task automatic beat(logic rdy);
    @(negedge clk);
    bus.i_uinst_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_minst_valid = 1'b0;
    bus.i_uinst_ready = 1'b1;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_busy: got valid=%b busy=%b, expected 0 0", bus.o_uinst_valid, busy);
    end
    checks++;
    if (bus.o_minst_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_minst_ready: got %b, expected 1", bus.o_minst_ready);
    end
    checks++;
    if (bus.o_uinst_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", bus.o_uinst_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int exp_rf[6]  = '{10, 11, 12, 13, 14, 15};
    int exp_acc[6] = '{4, 4, 4, 5, 5, 5};
    int exp_op[6]  = '{0, 1, 2, 0, 1, 2};
    send_macro(10, 2, 1, 4, 0, 1, 8'hA5);
    for (int k = 0; k < 6; k++) begin
      beat(1'b1);
      checks++;
      if (bus.o_uinst_valid !== 1'b1 || busy !== 1'b1 ||
          bus.o_uinst_data !== pack_ui(8'hA5, exp_rf[k], 1, exp_acc[k], exp_op[k])) begin
        errors++;
        $display("FAIL basic_beat%0d: got valid=%b busy=%b data=%h, expected 1 1 %h", k,
                 bus.o_uinst_valid, busy, bus.o_uinst_data,
                 pack_ui(8'hA5, exp_rf[k], 1, exp_acc[k], exp_op[k]));
      end
      checks++;
      if (bus.o_minst_ready !== (k == 5)) begin
        errors++;
        $display("FAIL basic_minst_ready%0d: got %b, expected %b", k, bus.o_minst_ready, k == 5);
      end
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got valid=%b busy=%b, expected 0 0", bus.o_uinst_valid, busy);
    end
  endtask

  task automatic test_single_chunk();
    send_macro(40, 0, 2, 100, 1, 0, 8'h33);
    for (int k = 0; k < 3; k++) begin
      beat(1'b1);
      checks++;
      if (bus.o_uinst_valid !== 1'b1 ||
          bus.o_uinst_data !== pack_ui(8'h33, 40 + k, 0, 100 + k, 3)) begin
        errors++;
        $display("FAIL single_beat%0d: got valid=%b data=%h, expected 1 %h", k,
                 bus.o_uinst_valid, bus.o_uinst_data, pack_ui(8'h33, 40 + k, 0, 100 + k, 3));
      end
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got valid=%b, expected 0", bus.o_uinst_valid);
    end
  endtask

  task automatic test_wrap();
    int exp_rf[8]  = '{510, 511, 0, 1, 2, 3, 4, 5};
    int exp_acc[8] = '{511, 511, 511, 511, 0, 0, 0, 0};
    int exp_op[8]  = '{0, 1, 1, 2, 0, 1, 1, 2};
    send_macro(510, 3, 1, 511, 0, 1, 8'h7E);
    for (int k = 0; k < 8; k++) begin
      beat(1'b1);
      checks++;
      if (bus.o_uinst_valid !== 1'b1 ||
          bus.o_uinst_data !== pack_ui(8'h7E, exp_rf[k], 1, exp_acc[k], exp_op[k])) begin
        errors++;
        $display("FAIL wrap_beat%0d: got valid=%b data=%h, expected 1 %h", k,
                 bus.o_uinst_valid, bus.o_uinst_data,
                 pack_ui(8'h7E, exp_rf[k], 1, exp_acc[k], exp_op[k]));
      end
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: got valid=%b, expected 0", bus.o_uinst_valid);
    end
  endtask

  task automatic test_backpressure();
    int exp_rf[6]  = '{10, 11, 12, 13, 14, 15};
    int exp_acc[6] = '{4, 4, 4, 5, 5, 5};
    int exp_op[6]  = '{0, 1, 2, 0, 1, 2};
    logic sched[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int k = 0;
    int xfers = 0;
    send_macro(10, 2, 1, 4, 0, 0, 8'h5A);
    for (int i = 0; i < 9; i++) begin
      beat(sched[i]);
      checks++;
      if (bus.o_uinst_valid !== 1'b1 ||
          bus.o_uinst_data !== pack_ui(8'h5A, exp_rf[k], 0, exp_acc[k], exp_op[k])) begin
        errors++;
        $display("FAIL bp_cycle%0d: got valid=%b data=%h, expected 1 %h", i,
                 bus.o_uinst_valid, bus.o_uinst_data,
                 pack_ui(8'h5A, exp_rf[k], 0, exp_acc[k], exp_op[k]));
      end
      if (!sched[i]) begin
        checks++;
        if (bus.o_minst_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall_ready%0d: got %b, expected 0", i, bus.o_minst_ready);
        end
      end
      if (bus.o_uinst_valid === 1'b1 && sched[i]) xfers++;
      if (sched[i] && k < 5) k++;
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0 || xfers != 6) begin
      errors++;
      $display("FAIL bp_total: got valid=%b transfers=%0d, expected 0 6", bus.o_uinst_valid, xfers);
    end
  endtask

  task automatic test_back_to_back();
    send_macro(100, 1, 0, 20, 0, 0, 8'h11);
    beat(1'b1);
    checks++;
    if (bus.o_uinst_data !== pack_ui(8'h11, 100, 0, 20, 0)) begin
      errors++;
      $display("FAIL b2b_a0: got %h, expected %h", bus.o_uinst_data, pack_ui(8'h11, 100, 0, 20, 0));
    end
    @(negedge clk);
    bus.i_uinst_ready = 1'b1;
    set_fields(200, 0, 1, 30, 1, 1, 8'h22);
    bus.i_minst_valid = 1'b1;
    #1;
    checks++;
    if (bus.o_uinst_data !== pack_ui(8'h11, 101, 0, 20, 2) || bus.o_minst_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a1: got data=%h ready=%b, expected %h 1", bus.o_uinst_data,
               bus.o_minst_ready, pack_ui(8'h11, 101, 0, 20, 2));
    end
    @(negedge clk);
    bus.i_minst_valid = 1'b0;
    set_fields(341, 7, 5, 77, 0, 0, 8'hEE);
    #1;
    checks++;
    if (bus.o_uinst_valid !== 1'b1 || bus.o_uinst_data !== pack_ui(8'h22, 200, 1, 30, 3)) begin
      errors++;
      $display("FAIL b2b_b0: got valid=%b data=%h, expected 1 %h", bus.o_uinst_valid,
               bus.o_uinst_data, pack_ui(8'h22, 200, 1, 30, 3));
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b1 || bus.o_uinst_data !== pack_ui(8'h22, 201, 1, 31, 3)) begin
      errors++;
      $display("FAIL b2b_b1: got valid=%b data=%h, expected 1 %h", bus.o_uinst_valid,
               bus.o_uinst_data, pack_ui(8'h22, 201, 1, 31, 3));
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got valid=%b, expected 0", bus.o_uinst_valid);
    end
  endtask

  task automatic test_reset_mid_issue();
    send_macro(50, 3, 0, 7, 0, 0, 8'h44);
    beat(1'b1);
    beat(1'b1);
    @(negedge clk);
    bus.i_uinst_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_uinst_valid !== 1'b0 || busy !== 1'b0 || bus.o_minst_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got valid=%b busy=%b ready=%b, expected 0 0 1",
               bus.o_uinst_valid, busy, bus.o_minst_ready);
    end
    send_macro(300, 1, 0, 9, 1, 0, 8'h3C);
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b1 || bus.o_uinst_data !== pack_ui(8'h3C, 300, 0, 9, 1)) begin
      errors++;
      $display("FAIL rst_after0: got valid=%b data=%h, expected 1 %h", bus.o_uinst_valid,
               bus.o_uinst_data, pack_ui(8'h3C, 300, 0, 9, 1));
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b1 || bus.o_uinst_data !== pack_ui(8'h3C, 301, 0, 9, 3)) begin
      errors++;
      $display("FAIL rst_after1: got valid=%b data=%h, expected 1 %h", bus.o_uinst_valid,
               bus.o_uinst_data, pack_ui(8'h3C, 301, 0, 9, 3));
    end
    beat(1'b1);
    checks++;
    if (bus.o_uinst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_done: got valid=%b, expected 0", bus.o_uinst_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_single_chunk();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
